// File: rtl/mux_scan_ctrl.sv
// Round-robin scan sequencer for a 4:1 mux: settle, capture Y, hand off over valid/ready.
// Optional MUX_SCAN_PARITY_EN adds a per-frame XOR of accepted sample bits on frame_parity.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | not scanning; waits for start with a non-empty channel mask
// SETTLE  | S driven, settle counter running down to capture
// PRESENT | captured sample held on sample_* until downstream accepts it
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         chan_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         S,
  input  logic               Y,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [1:0]         sample_chan,
  output logic               sample_bit,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_parity
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [3:0]         mask, mask_nx;
  logic [1:0]         sel_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx, dwell_ld;
  logic               valid_nx, bit_nx, fd_nx;
  logic [1:0]         chan_nx;
  logic               accept, boundary;

  function automatic logic [1:0] lowest_idx(input logic [3:0] m);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_idx = i[1:0];
  endfunction

  function automatic logic [1:0] highest_idx(input logic [3:0] m);
    highest_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (m[i]) highest_idx = i[1:0];
  endfunction

  // Smallest enabled index above cur; wraps to the lowest enabled one.
  function automatic logic [1:0] next_idx(input logic [3:0] m, input logic [1:0] cur);
    next_idx = lowest_idx(m);
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(cur))) next_idx = i[1:0];
  endfunction

  assign dwell_ld = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign accept   = sample_valid && sample_ready;
  assign boundary = accept && (S == highest_idx(mask));
  assign busy     = (state != ST_IDLE);

`ifdef MUX_SCAN_PARITY_EN
  logic acc, acc_nx, par_nx;
`endif

  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    sel_nx   = S;
    cnt_nx   = cnt;
    valid_nx = sample_valid;
    chan_nx  = sample_chan;
    bit_nx   = sample_bit;
    fd_nx    = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    acc_nx   = acc;
    par_nx   = frame_parity;
`endif
    case (state)
      ST_IDLE: begin
        if (start && (chan_en != 4'b0000)) begin
          mask_nx  = chan_en;
          sel_nx   = lowest_idx(chan_en);
          cnt_nx   = dwell_ld;
          state_nx = ST_SETTLE;
`ifdef MUX_SCAN_PARITY_EN
          acc_nx   = 1'b0;
`endif
        end
      end
      ST_SETTLE: begin
        if (cnt <= DWELL_W'(1)) begin
          cnt_nx   = '0;
          bit_nx   = Y;
          chan_nx  = S;
          valid_nx = 1'b1;
          state_nx = ST_PRESENT;
        end else begin
          cnt_nx = cnt - DWELL_W'(1);
        end
      end
      ST_PRESENT: begin
        if (accept) begin
          valid_nx = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
          acc_nx   = acc ^ sample_bit;
`endif
          if (boundary) begin
            fd_nx   = 1'b1;
            mask_nx = chan_en;
`ifdef MUX_SCAN_PARITY_EN
            par_nx  = acc ^ sample_bit;
            acc_nx  = 1'b0;
`endif
          end
          // A frame boundary with an empty new mask ends the scan like stop does.
          if (stop || (boundary && (chan_en == 4'b0000))) begin
            state_nx = ST_IDLE;
          end else begin
            sel_nx   = boundary ? lowest_idx(chan_en) : next_idx(mask, S);
            cnt_nx   = dwell_ld;
            state_nx = ST_SETTLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask         <= 4'b0000;
      S            <= 2'd0;
      cnt          <= '0;
      sample_valid <= 1'b0;
      sample_chan  <= 2'd0;
      sample_bit   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      mask         <= mask_nx;
      S            <= sel_nx;
      cnt          <= cnt_nx;
      sample_valid <= valid_nx;
      sample_chan  <= chan_nx;
      sample_bit   <= bit_nx;
      frame_done   <= fd_nx;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc          <= 1'b0;
      frame_parity <= 1'b0;
    end else begin
      acc          <= acc_nx;
      frame_parity <= par_nx;
    end
  end
`else
  assign frame_parity = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: table of scan configurations plus directed corner sequences,
// with a queue of expected samples checked at each handshake.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, sample_ready;
  logic [3:0] chan_en, dwell, dval;
  logic [1:0] S, sample_chan;
  logic       Y, sample_valid, sample_bit, busy, frame_done, frame_parity;

  assign Y = dval[S];

  mux_scan_ctrl #(.DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .chan_en(chan_en),
    .dwell(dwell), .S(S), .Y(Y), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_chan(sample_chan), .sample_bit(sample_bit),
    .busy(busy), .frame_done(frame_done), .frame_parity(frame_parity)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] chan; logic bitv; logic last; logic par; } exp_t;
  typedef struct { logic [3:0] en; logic [3:0] dw; logic [3:0] d; int per; logic par; } vec_t;

  exp_t q[$];
  exp_t mon_it;
  vec_t vt[6];

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, last_rise = -1, first_mark = 0, exp_first = 0, exp_period = 0;
  logic mon_en = 1'b0, first_pending = 1'b0, exp_fd = 1'b0, exp_par_q = 1'b0, prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [3:0] m, input logic [3:0] d, input logic par);
    exp_t it;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        it.chan = i[1:0];
        it.bitv = d[i];
        it.last = ((m >> (i + 1)) == 4'b0000);
        it.par  = par;
        q.push_back(it);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " S"}, S, 0);
    check({tag, " valid"}, sample_valid, 0);
    check({tag, " chan"}, sample_chan, 0);
    check({tag, " bit"}, sample_bit, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " frame_parity"}, frame_parity, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    start = 1'b0; stop = 1'b0; sample_ready = 1'b1;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    q.delete();
    exp_fd = 1'b0; first_pending = 1'b0; last_rise = -1;
    mon_en = 1'b1;
  endtask

  task automatic start_scan(input logic [3:0] en, input logic [3:0] dw, input logic [3:0] d, input int lat);
    chan_en = en; dwell = dw; dval = d;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    first_mark = cyc + 1;
    exp_first = lat;
    first_pending = 1'b1;
  endtask

  task automatic drain_and_check_idle(input string tag);
    int k;
    for (k = 0; k < 2000 && q.size() != 0; k++) cycles(1);
    if (q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL %s drain timeout: %0d samples outstanding, expected 0", tag, q.size());
      q.delete();
    end
    cycles(3);
    check({tag, " busy after end"}, busy, 0);
    check({tag, " valid after end"}, sample_valid, 0);
  endtask

  // Raise stop after the next-to-last expected sample is accepted.
  task automatic stop_after_last(input string tag);
    int k;
    for (k = 0; k < 2000 && q.size() > 1; k++) cycles(1);
    if (q.size() > 1) begin
      n_vec++; n_err++;
      $display("FAIL %s stop wait timeout: %0d samples outstanding, expected 1", tag, q.size());
      q.delete();
    end
    stop = 1'b1;
    drain_and_check_idle(tag);
    stop = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("frame_done", frame_done, exp_fd);
`ifdef MUX_SCAN_PARITY_EN
      if (frame_done) check("frame_parity", frame_parity, exp_par_q);
`else
      check("frame_parity", frame_parity, 0);
`endif
      exp_fd = 1'b0;
      if (sample_valid && !prev_valid) begin
        if (first_pending) begin
          check("first latency", cyc - first_mark, exp_first);
          first_pending = 1'b0;
        end else if (exp_period != 0) begin
          check("sample period", cyc - last_rise, exp_period);
        end
        last_rise = cyc;
      end
      if (sample_valid && sample_ready) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected sample: chan %0d bit %0d, expected none", sample_chan, sample_bit);
        end else begin
          mon_it = q.pop_front();
          check("sample_chan", sample_chan, mon_it.chan);
          check("sample_bit", sample_bit, mon_it.bitv);
          check("S at accept", S, mon_it.chan);
          exp_fd = mon_it.last;
          if (mon_it.last) exp_par_q = mon_it.par;
        end
      end
    end
    prev_valid = sample_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {chan_en, dwell, D4..D1, sample period, expected frame parity}
    vt[0] = '{4'b1111, 4'd2,  4'b1010, 3,  1'b0};
    vt[1] = '{4'b1010, 4'd0,  4'b1010, 2,  1'b0};
    vt[2] = '{4'b1111, 4'd1,  4'b0010, 2,  1'b1};
    vt[3] = '{4'b0100, 4'd3,  4'b0100, 4,  1'b1};
    vt[4] = '{4'b1001, 4'd15, 4'b0001, 16, 1'b1};
    vt[5] = '{4'b0111, 4'd2,  4'b0111, 3,  1'b1};

    chan_en = 4'b0000; dwell = 4'd0; dval = 4'b0000;
    do_reset();
    check_idle("reset");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      exp_period = vt[v].per;
      push_frame(vt[v].en, vt[v].d, vt[v].par);
      push_frame(vt[v].en, vt[v].d, vt[v].par);
      start_scan(vt[v].en, vt[v].dw, vt[v].d, vt[v].per - 1);
      stop_after_last("vector");
    end

    // Reset in the middle of a scan drops everything.
    do_reset();
    mon_en = 1'b0;
    start_scan(4'b1111, 4'd2, 4'b1010, 2);
    cycles(5);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    check_idle("mid-scan reset");
    cycles(1);
    check("busy one cycle after reset", busy, 0);

    // Backpressure: valid and data held while ready is low.
    do_reset();
    exp_period = 0;
    sample_ready = 1'b0;
    push_frame(4'b1111, 4'b1011, 1'b1);
    start_scan(4'b1111, 4'd1, 4'b1011, 1);
    for (int k = 0; k < 50 && !sample_valid; k++) cycles(1);
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check("bp valid held", sample_valid, 1);
      check("bp S held", S, 0);
      check("bp chan held", sample_chan, 0);
      check("bp bit held", sample_bit, 1);
    end
    sample_ready = 1'b1;
    stop_after_last("backpressure");

    // Mid-frame mask change applies from the next frame.
    do_reset();
    exp_period = 3;
    push_frame(4'b1111, 4'b1010, 1'b0);
    push_frame(4'b0011, 4'b1010, 1'b1);
    start_scan(4'b1111, 4'd2, 4'b1010, 2);
    chan_en = 4'b0011;
    stop_after_last("mask change");

    // Mask re-latched empty at the frame boundary ends the scan.
    do_reset();
    exp_period = 2;
    push_frame(4'b0101, 4'b0101, 1'b0);
    start_scan(4'b0101, 4'd1, 4'b0101, 1);
    chan_en = 4'b0000;
    drain_and_check_idle("empty relatch");

    // start and stop together: exactly one sample, then IDLE.
    do_reset();
    exp_period = 0;
    push_frame(4'b0001, 4'b1010, 1'b0);
    q[0].last = 1'b0;
    stop = 1'b1;
    start_scan(4'b1111, 4'd2, 4'b1010, 2);
    drain_and_check_idle("start+stop");
    stop = 1'b0;

    // Start with an empty mask is ignored.
    do_reset();
    chan_en = 4'b0000;
    start = 1'b1;
    cycles(3);
    check("empty start busy", busy, 0);
    check("empty start valid", sample_valid, 0);
    check("empty start S", S, 0);
    start = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
